// File: rtl/tick_scheduler.sv
// Paces the Chip-8 core with a programmable-rate cpu_tick and a fixed-rate timer_tick, plus run/pause/single-step control.
// All outputs registered; a new divisor waits in a one-entry slot (cfg_ready low) until the next tick boundary or pause.
module tick_scheduler #(
   parameter int CLK_HZ      = 50000000,
   parameter int TIMER_HZ    = 60,
   parameter int DIV_W       = 20,
   parameter int DEFAULT_DIV = 100000
) (
   input  logic             clk_in,
   input  logic             res,
   input  logic [DIV_W-1:0] cfg_div,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             pause,
   input  logic             step,
   output logic             cpu_tick,
   output logic             timer_tick,
   output logic [DIV_W-1:0] cur_div,
   output logic             paused
);

   localparam int TDIV_RAW = CLK_HZ / TIMER_HZ;
   localparam int TDIV     = (TDIV_RAW < 1) ? 1 : TDIV_RAW;
   localparam int TW       = (TDIV > 1) ? $clog2(TDIV) : 1;
   localparam logic [TW-1:0]    TMAX    = TW'(TDIV - 1);
   localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_PAUSED = 2'd1,
      ST_STEP   = 2'd2
   } state_t;

   state_t             state_q, state_nxt;
   logic [DIV_W-1:0]   cnt_q, cnt_nxt;
   logic [TW-1:0]      tcnt_q, tcnt_nxt;
   logic [DIV_W-1:0]   pend_q, pend_nxt;
   logic               pend_vld_q, pend_vld_nxt;
   logic [DIV_W-1:0]   cur_div_q, cur_div_nxt;
   logic               cpu_tick_q, cpu_tick_nxt;
   logic               timer_tick_q, timer_tick_nxt;
   logic               cfg_ready_q, cfg_ready_nxt;
   logic               paused_q, paused_nxt;

   logic               accept;
   logic               apply;
   logic [DIV_W-1:0]   pend_eff;
   logic [DIV_W-1:0]   div_now;
   logic               cpu_wrap;
   logic               tmr_wrap;

   assign accept   = cfg_valid && cfg_ready_q;
   // A pending divisor lands right after a tick in RUN, or at once while paused.
   assign apply    = pend_vld_q && ((state_q == ST_RUN && cpu_tick_q) || state_q == ST_PAUSED);
   assign pend_eff = (pend_q == '0) ? DIV_W'(1) : pend_q;
   // The restart after an applying tick already runs at the new rate.
   assign div_now  = apply ? pend_eff : cur_div_q;
   assign cpu_wrap = (div_now <= DIV_W'(1)) || (cnt_q >= div_now - DIV_W'(1));
   assign tmr_wrap = (tcnt_q == TMAX);

   always_comb begin
      state_nxt      = state_q;
      cnt_nxt        = cnt_q;
      tcnt_nxt       = tcnt_q;
      cpu_tick_nxt   = 1'b0;
      timer_tick_nxt = 1'b0;
      cur_div_nxt    = cur_div_q;
      pend_nxt       = pend_q;
      pend_vld_nxt   = pend_vld_q;

      case (state_q)
         ST_RUN: begin
            if (cpu_wrap) begin
               cnt_nxt      = '0;
               cpu_tick_nxt = 1'b1;
            end else begin
               cnt_nxt = cnt_q + DIV_W'(1);
            end
            if (tmr_wrap) begin
               tcnt_nxt       = '0;
               timer_tick_nxt = 1'b1;
            end else begin
               tcnt_nxt = tcnt_q + TW'(1);
            end
            if (pause) begin
               state_nxt = ST_PAUSED;
            end
         end
         ST_PAUSED: begin
            cnt_nxt = '0;
            if (!pause) begin
               state_nxt = ST_RUN;
            end else if (step) begin
               state_nxt = ST_STEP;
            end
         end
         ST_STEP: begin
            cnt_nxt      = '0;
            cpu_tick_nxt = 1'b1;
            state_nxt    = ST_PAUSED;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = ST_RUN;
         end
      endcase

      // apply and accept are exclusive: cfg_ready is low whenever the slot is full.
      if (apply) begin
         cur_div_nxt  = pend_eff;
         pend_vld_nxt = 1'b0;
      end else if (accept) begin
         pend_nxt     = cfg_div;
         pend_vld_nxt = 1'b1;
      end

      cfg_ready_nxt = !pend_vld_nxt;
      paused_nxt    = (state_nxt != ST_RUN);
   end

   always_ff @(posedge clk_in) begin
      if (res) begin
         state_q      <= ST_RUN;
         cnt_q        <= '0;
         tcnt_q       <= '0;
         pend_q       <= '0;
         pend_vld_q   <= 1'b0;
         cur_div_q    <= DIV_RST;
         cpu_tick_q   <= 1'b0;
         timer_tick_q <= 1'b0;
         cfg_ready_q  <= 1'b1;
         paused_q     <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         cnt_q        <= cnt_nxt;
         tcnt_q       <= tcnt_nxt;
         pend_q       <= pend_nxt;
         pend_vld_q   <= pend_vld_nxt;
         cur_div_q    <= cur_div_nxt;
         cpu_tick_q   <= cpu_tick_nxt;
         timer_tick_q <= timer_tick_nxt;
         cfg_ready_q  <= cfg_ready_nxt;
         paused_q     <= paused_nxt;
      end
   end

   assign cpu_tick   = cpu_tick_q;
   assign timer_tick = timer_tick_q;
   assign cfg_ready  = cfg_ready_q;
   assign cur_div    = cur_div_q;
   assign paused     = paused_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed test-plan phases plus a randomized run, checked against a timestamp-based scheduling model.
module tb_tick_scheduler;

   localparam int CLK_HZ   = 600;
   localparam int TIMER_HZ = 60;
   localparam int TDIV     = CLK_HZ / TIMER_HZ;
   localparam int DIV_W    = 8;
   localparam int DEF      = 4;

   localparam int M_RUN    = 0;
   localparam int M_PAUSED = 1;
   localparam int M_STEP   = 2;

   logic             clk_in;
   logic             res;
   logic [DIV_W-1:0] cfg_div;
   logic             cfg_valid;
   logic             cfg_ready;
   logic             pause;
   logic             step;
   logic             cpu_tick;
   logic             timer_tick;
   logic [DIV_W-1:0] cur_div;
   logic             paused;

   tick_scheduler #(
      .CLK_HZ     (CLK_HZ),
      .TIMER_HZ   (TIMER_HZ),
      .DIV_W      (DIV_W),
      .DEFAULT_DIV(DEF)
   ) dut (
      .clk_in    (clk_in),
      .res       (res),
      .cfg_div   (cfg_div),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .pause     (pause),
      .step      (step),
      .cpu_tick  (cpu_tick),
      .timer_tick(timer_tick),
      .cur_div   (cur_div),
      .paused    (paused)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   int n_vec = 0;
   int n_bad = 0;

   // Reference model: absolute due-cycle scheduling and a count of running edges.
   int m_cyc = 0;
   int m_due = 0;
   int m_run_edges = 0;
   int m_div = DEF;
   int m_div_raw = DEF;
   int m_pend = 0;
   bit m_pend_vld = 1'b0;
   int m_mode = M_RUN;
   bit e_cpu = 1'b0;
   bit e_tmr = 1'b0;
   bit e_ready = 1'b1;
   bit e_paused = 1'b0;

   function automatic int eff(input int d);
      return (d == 0) ? 1 : d;
   endfunction

   task automatic chk(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_edge();
      int  was_mode;
      bit  was_tick;
      m_cyc++;
      if (res) begin
         m_mode = M_RUN;
         m_due = m_cyc + DEF;
         m_run_edges = 0;
         m_pend_vld = 1'b0;
         m_div = DEF;
         m_div_raw = DEF;
         e_cpu = 1'b0;
         e_tmr = 1'b0;
         e_ready = 1'b1;
         e_paused = 1'b0;
      end else begin
         was_mode = m_mode;
         was_tick = e_cpu;
         if (m_pend_vld && ((was_mode == M_RUN && was_tick) || was_mode == M_PAUSED)) begin
            m_div = eff(m_pend);
            m_div_raw = m_pend;
            m_pend_vld = 1'b0;
         end else if (cfg_valid && e_ready) begin
            m_pend = int'(cfg_div);
            m_pend_vld = 1'b1;
         end
         if (was_mode == M_RUN) begin
            m_run_edges++;
            e_tmr = ((m_run_edges % TDIV) == 0);
            e_cpu = (m_cyc == m_due);
            if (e_cpu) m_due = m_cyc + (m_pend_vld ? eff(m_pend) : m_div);
            if (pause) m_mode = M_PAUSED;
         end else if (was_mode == M_PAUSED) begin
            e_cpu = 1'b0;
            e_tmr = 1'b0;
            if (!pause) begin
               m_mode = M_RUN;
               m_due = m_cyc + m_div;
            end else if (step) begin
               m_mode = M_STEP;
            end
         end else begin
            e_cpu = 1'b1;
            e_tmr = 1'b0;
            m_mode = M_PAUSED;
         end
         e_ready = !m_pend_vld;
         e_paused = (m_mode != M_RUN);
      end
   endtask

   task automatic cyc(input bit r, input bit p, input bit s, input bit v, input int d);
      res = r;
      pause = p;
      step = s;
      cfg_valid = v;
      cfg_div = DIV_W'(d);
      @(posedge clk_in);
      model_edge();
      #1;
      chk("m_cpu_tick", int'(cpu_tick), int'(e_cpu));
      chk("m_timer_tick", int'(timer_tick), int'(e_tmr));
      chk("m_cfg_ready", int'(cfg_ready), int'(e_ready));
      chk("m_paused", int'(paused), int'(e_paused));
      if (m_div_raw != 0) chk("m_cur_div", int'(cur_div), m_div_raw);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cpu"}, int'(cpu_tick), 0);
      chk({tag, "_tmr"}, int'(timer_tick), 0);
      chk({tag, "_ready"}, int'(cfg_ready), 1);
      chk({tag, "_paused"}, int'(paused), 0);
      chk({tag, "_div"}, int'(cur_div), DEF);
   endtask

   initial begin
      bit rp;
      bit rv;
      res = 1'b1;
      pause = 1'b0;
      step = 1'b0;
      cfg_valid = 1'b0;
      cfg_div = '0;

      // Reset state and 40-cycle free run
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk_reset_vals("rst");
      for (int n = 1; n <= 40; n++) begin
         cyc(0, 0, 0, 0, 0);
         chk("p1_cpu", int'(cpu_tick), int'(n % 4 == 0));
         chk("p1_tmr", int'(timer_tick), int'(n % 10 == 0));
         chk("p1_div", int'(cur_div), DEF);
      end

      // Divisor 6 offered in cycle 5, applied at the tick in cycle 8
      cyc(1, 0, 0, 0, 0);
      for (int n = 1; n <= 22; n++) begin
         cyc(0, 0, 0, n == 6, 6);
         chk("p2_ready", int'(cfg_ready), int'(n < 6 || n > 8));
         chk("p2_cpu", int'(cpu_tick), int'(n == 4 || n == 8 || n == 14 || n == 20));
         chk("p2_div", int'(cur_div), (n >= 9) ? 6 : 4);
      end

      // Pause sampled on a due tick, timer phase held across the pause
      cyc(1, 0, 0, 0, 0);
      for (int n = 1; n <= 34; n++) begin
         cyc(0, n >= 8 && n <= 20, 0, 0, 0);
         chk("p3_cpu", int'(cpu_tick), int'((n <= 8 && n % 4 == 0) || (n >= 25 && (n - 21) % 4 == 0)));
         chk("p3_tmr", int'(timer_tick), int'(n == 23 || n == 33));
         chk("p3_paused", int'(paused), int'(n >= 8 && n <= 20));
      end

      // Three single steps while paused; step with resume and step in RUN are dropped
      cyc(1, 0, 0, 0, 0);
      for (int n = 1; n <= 30; n++) begin
         cyc(0, n >= 2 && n <= 20, n == 6 || n == 11 || n == 16 || n == 21 || n == 23, 0, 0);
         chk("p4_cpu", int'(cpu_tick), int'(n == 7 || n == 12 || n == 17 || n == 25 || n == 29));
         chk("p4_paused", int'(paused), int'(n >= 2 && n <= 20));
      end

      // Divisor 0 behaves as 1, then divisor 1
      cyc(1, 0, 0, 0, 0);
      for (int n = 1; n <= 16; n++) begin
         cyc(0, 0, 0, n == 2 || n == 10, (n == 10) ? 1 : 0);
         chk("p5_cpu", int'(cpu_tick), int'(n >= 4));
         if (n <= 4) chk("p5_div_old", int'(cur_div), DEF);
         if (n >= 11) chk("p5_div_one", int'(cur_div), 1);
      end

      // Reset mid-period with a divisor pending
      cyc(1, 0, 0, 0, 0);
      for (int n = 1; n <= 7; n++) begin
         cyc(n == 7, 0, 0, n == 6, 6);
      end
      chk_reset_vals("p6_rst");
      for (int n = 1; n <= 13; n++) begin
         cyc(0, 0, 0, 0, 0);
         chk("p6_cpu", int'(cpu_tick), int'(n % 4 == 0));
         chk("p6_div", int'(cur_div), DEF);
         chk("p6_ready", int'(cfg_ready), 1);
      end

      // Randomized traffic against the model
      rp = 1'b0;
      rv = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 19) == 0) rp = !rp;
         rv = rv ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
         cyc($urandom_range(0, 499) == 0, rp, $urandom_range(0, 5) == 0, rv,
             int'($urandom_range(0, 9)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/tick_scheduler.md
# tick_scheduler

Generates the single-cycle clock-enable strobes that pace the Chip-8 core: a CPU instruction tick at a runtime-programmable rate and a fixed 60 Hz delay/sound-timer tick, both derived by counting the system clock. It replaces free-running divided clocks in the core's timing path. It also owns run/pause/single-step sequencing for the OSD and debugger, and handles glitch-free divisor reconfiguration.

## Interface
Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz
- TIMER_HZ, 60, timer tick rate; timer divisor TDIV = CLK_HZ / TIMER_HZ (integer, truncated)
- DIV_W, 20, width of CPU divisor
- DEFAULT_DIV, 100000, CPU divisor after reset (500 Hz at 50 MHz)

Ports:
- clk_in  in  1  system clock; sole clock, all logic on rising edge
- res  in  1  reset, synchronous, active-high
- cfg_div  in  DIV_W  requested CPU divisor (system cycles per cpu_tick)
- cfg_valid  in  1  cfg_div offered
- cfg_ready  out  1  scheduler can accept a new divisor
- pause  in  1  level; high requests paused state
- step  in  1  one-cycle pulse; requests a single cpu_tick while paused
- cpu_tick  out  1  one-cycle CPU enable strobe
- timer_tick  out  1  one-cycle timer enable strobe
- cur_div  out  DIV_W  divisor currently in effect
- paused  out  1  high in PAUSED and STEP states

## Operation
- All outputs registered. Reset values: cpu_tick 0, timer_tick 0, cfg_ready 1, paused 0, cur_div DEFAULT_DIV, state RUN, both counters 0, pending slot empty.
- CPU counter counts 0..cur_div-1 in RUN. cpu_tick is high in the cycle the counter wraps to 0.
- Timer counter counts 0..TDIV-1, independently of cur_div. timer_tick is high on wrap.
- Divisor 0 is treated as 1. Divisor 1 gives cpu_tick every cycle in RUN.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready; cfg_div is captured into a pending slot. cfg_ready drops the next cycle and stays low while the slot is full.
  - cfg_valid may be held; no transfer occurs while cfg_ready is low.
  - In RUN, the pending value is applied to cur_div in the cycle cpu_tick fires, and the counter restarts at 0. No short or stretched period is ever produced.
  - In PAUSED, the pending value is applied on the cycle after capture.
  - cfg_ready returns high the cycle after the pending value is applied.
- FSM states: RUN, PAUSED, STEP.
  - RUN → PAUSED when pause=1. RUN behaviour, including a tick falling due, continues during the sampling cycle.
  - PAUSED → RUN when pause=0. The CPU counter is cleared on this transition, so the first tick after resume comes a full cur_div cycles later.
  - PAUSED → STEP when pause=1 && step=1.
  - STEP → PAUSED unconditionally after one cycle. cpu_tick is high for exactly that STEP cycle.
- step is ignored in RUN and in STEP.
- In PAUSED, pause=0 together with step=1 goes to RUN; the step is dropped.
- In PAUSED and STEP the CPU counter is held at 0. The timer counter holds its value (phase preserved) and timer_tick is 0.
- res asserted at any point (mid-period, STEP, pending config) returns every register to its reset value on the next edge. A pending divisor is discarded.

## Timing
- After res deasserts with divisor D, cpu_tick is first high in the D-th cycle, then every D cycles. timer_tick is first high in the TDIV-th cycle.
- Latency: pause→paused=1 is 1 cycle. step (while paused) → cpu_tick is 2 cycles (PAUSED→STEP edge, then registered output).
- cpu_tick and timer_tick may be high in the same cycle. They are independent.
- The new divisor D' is visible on cur_div the cycle after the tick that applies it. The next tick follows D' cycles after the applying tick.

## Test plan
Bench parameters: CLK_HZ=600, TIMER_HZ=60 (TDIV=10), DEFAULT_DIV=4, DIV_W=8.
- Reset release, 40 cycles free run -> cpu_tick in cycles 4,8,…,40; timer_tick in cycles 10,20,30,40; paused=0, cur_div=4.
- cfg_div=6 offered at cycle 5 -> cfg_ready low from cycle 6. Ticks at 8 (applies), then 14, 20. cur_div=6 from cycle 9. cfg_ready high at cycle 9.
- pause=1 asserted in a cycle where a tick is due -> that tick still emitted, paused=1 next cycle, no cpu_tick/timer_tick while paused. After pause=0, next cpu_tick comes exactly 4 cycles later; timer resumes its held phase.
- While paused, three step pulses spaced 5 cycles apart -> exactly three single-cycle cpu_ticks, each 2 cycles after its step. Step issued in RUN -> no extra tick.
- cfg_div=0 applied -> cpu_tick every cycle. Then cfg_div=1 -> unchanged behaviour, cur_div=1.
- res asserted mid-period with a pending divisor -> all outputs at reset values next cycle, pending discarded, cadence restarts at divisor 4.
